// File: rtl/pwm_interrupt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_interrupt_scheduler
// Function : Per-channel PWM event decimator. Raises pulse or sticky
//            (pending/ack) interrupts with overrun detection.
// Revision : 1.0  initial multi-channel release
// ============================================================================
module pwm_interrupt_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int COUNT_WIDTH = 16,
  parameter bit RESET_MODE  = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pwm_onoff,
  input  logic [NUM_CH-1:0]             int_onoff,
  input  logic [NUM_CH-1:0]             mask_event,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] event_count,
  input  logic [NUM_CH-1:0]             mode,
  input  logic [NUM_CH-1:0]             ack,
  output logic [NUM_CH-1:0]             irq_pulse,
  output logic [NUM_CH-1:0]             pending,
  output logic [NUM_CH-1:0]             overrun,
  output logic                          irq
);

  localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0] mask_event_q;
  logic [NUM_CH-1:0] mode_q;
  logic              armed_q;
  logic [NUM_CH-1:0] irq_pulse_q, irq_pulse_d;
  logic [NUM_CH-1:0] pending_q,   pending_d;
  logic [NUM_CH-1:0] overrun_q,   overrun_d;
  logic              irq_q,       irq_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] n_w;
    logic                   edge_w, wrap_w, fire_w, sticky_fire_w;

    assign n_w = event_count[c*COUNT_WIDTH +: COUNT_WIDTH];

    // The first cycle after reset only primes mask_event_q, so a strobe held
    // high across reset is not mistaken for a fresh edge.
    assign edge_w        = armed_q & mask_event[c] & ~mask_event_q[c];
    assign wrap_w        = pwm_onoff & edge_w & (cnt_q >= n_w);
    assign fire_w        = wrap_w & int_onoff[c];
    assign sticky_fire_w = fire_w & mode_q[c];

    always_comb begin
      cnt_d = cnt_q;
      if (!pwm_onoff) begin
        cnt_d = '0;
      end else if (wrap_w) begin
        cnt_d = '0;
      end else if (edge_w) begin
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // A sticky fire beats a same-cycle ack; the ack still consumes the old
    // interrupt, so that collision never counts as an overrun.
    assign irq_pulse_d[c] = fire_w;
    assign pending_d[c]   = sticky_fire_w | (pending_q[c] & ~ack[c]);
    assign overrun_d[c]   = (sticky_fire_w & pending_q[c] & ~ack[c])
                          | (overrun_q[c] & ~ack[c]);
  end

  assign irq_d = |(irq_pulse_d | pending_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_event_q <= '0;
      mode_q       <= {NUM_CH{RESET_MODE}};
      armed_q      <= 1'b0;
      irq_pulse_q  <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      mask_event_q <= mask_event;
      mode_q       <= mode;
      armed_q      <= 1'b1;
      irq_pulse_q  <= irq_pulse_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      irq_q        <= irq_d;
    end
  end

  assign irq_pulse = irq_pulse_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_interrupt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_interrupt_scheduler
// Function : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_interrupt_scheduler;

  localparam int NUM_CH = 4;
  localparam int CW     = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 pwm_onoff;
  logic [NUM_CH-1:0]    int_onoff;
  logic [NUM_CH-1:0]    mask_event;
  logic [NUM_CH*CW-1:0] event_count;
  logic [NUM_CH-1:0]    mode;
  logic [NUM_CH-1:0]    ack;
  logic [NUM_CH-1:0]    irq_pulse;
  logic [NUM_CH-1:0]    pending;
  logic [NUM_CH-1:0]    overrun;
  logic                 irq;

  pwm_interrupt_scheduler #(
    .NUM_CH      (NUM_CH),
    .COUNT_WIDTH (CW),
    .RESET_MODE  (1'b0)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pwm_onoff   (pwm_onoff),
    .int_onoff   (int_onoff),
    .mask_event  (mask_event),
    .event_count (event_count),
    .mode        (mode),
    .ack         (ack),
    .irq_pulse   (irq_pulse),
    .pending     (pending),
    .overrun     (overrun),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;
  int pcnt [NUM_CH];
  int irq_seen;

  // Behavioural model: events since the last wrap, plus flag bookkeeping.
  int m_cnt  [NUM_CH];
  bit m_prev [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_ovr  [NUM_CH];
  bit m_pulse[NUM_CH];
  bit m_mode [NUM_CH];
  bit m_armed;
  bit m_irq;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_prev[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
      m_pulse[c] = 0; m_mode[c] = 0;
    end
    m_armed = 0;
    m_irq   = 0;
  endfunction

  function automatic void model_clock();
    int n;
    bit seen, fire, was_pending;
    m_irq = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      n    = int'(event_count[c*CW +: CW]);
      seen = m_armed && mask_event[c] && !m_prev[c];
      fire = 0;
      m_prev[c] = mask_event[c];
      if (!pwm_onoff) m_cnt[c] = 0;
      else if (seen) begin
        if (m_cnt[c] >= n) begin
          m_cnt[c] = 0;
          fire     = int_onoff[c];
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
      m_pulse[c]  = fire;
      was_pending = m_pend[c];
      if (ack[c]) begin
        m_pend[c] = 0;
        m_ovr[c]  = 0;
      end
      if (fire && m_mode[c]) begin
        if (was_pending && !ack[c]) m_ovr[c] = 1;
        m_pend[c] = 1;
      end
      m_mode[c] = mode[c];
      if (m_pulse[c] || m_pend[c]) m_irq = 1;
    end
    m_armed = 1;
  endfunction

  task automatic check_model(input string name);
    logic [NUM_CH-1:0] ep, ek, eo;
    for (int c = 0; c < NUM_CH; c++) begin
      ep[c] = m_pulse[c]; ek[c] = m_pend[c]; eo[c] = m_ovr[c];
    end
    n_checks++;
    if (irq_pulse !== ep || pending !== ek || overrun !== eo || irq !== m_irq) begin
      n_err++;
      $display("FAIL %s t=%0t got pulse=%b pend=%b ovr=%b irq=%b, want pulse=%b pend=%b ovr=%b irq=%b",
               name, $time, irq_pulse, pending, overrun, irq, ep, ek, eo, m_irq);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick(input string name);
    model_clock();
    @(posedge clk);
    #1;
    check_model(name);
    for (int c = 0; c < NUM_CH; c++) if (irq_pulse[c]) pcnt[c]++;
    if (irq) irq_seen++;
  endtask

  task automatic edges(input int ch, input int num, input string name);
    for (int i = 0; i < num; i++) begin
      mask_event[ch] = 1'b1;
      tick(name);
      mask_event[ch] = 1'b0;
      for (int k = 0; k < 3; k++) tick(name);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NUM_CH; c++) pcnt[c] = 0;
    irq_seen = 0;
  endtask

  task automatic set_n(input int ch, input int n);
    event_count[ch*CW +: CW] = CW'(n);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ovr;
    logic              irq;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [3:0] ev, input logic [3:0] ak, input logic [3:0] p,
                              input logic [3:0] k, input logic [3:0] o, input logic i);
    vec_t v;
    v.ev = ev; v.ack = ak; v.pulse = p; v.pend = k; v.ovr = o; v.irq = i;
    return v;
  endfunction

  initial begin
    // ch1 sticky with N=1: fire on every second edge, overrun, ack, then a fire/ack collision.
    tbl[0]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[1]  = mk(4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[2]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[3]  = mk(4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 1'b1);
    tbl[4]  = mk(4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1);
    tbl[5]  = mk(4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1);
    tbl[6]  = mk(4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1);
    tbl[7]  = mk(4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 1'b1);
    tbl[8]  = mk(4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[9]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[10] = mk(4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[11] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tbl[12] = mk(4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 1'b1);
    tbl[13] = mk(4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1);
    tbl[14] = mk(4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1);
    tbl[15] = mk(4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1);
    tbl[16] = mk(4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 1'b1);
    tbl[17] = mk(4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1);

    reset_n     = 1'b0;
    pwm_onoff   = 1'b1;
    int_onoff   = '1;
    mask_event  = '0;
    mode        = 4'b0010;
    ack         = '0;
    event_count = {16'd3, 16'd3, 16'd1, 16'd3};
    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset_state");
    reset_n = 1'b1;
    repeat (2) tick("idle");

    for (int i = 0; i < 18; i++) begin
      mask_event = tbl[i].ev;
      ack        = tbl[i].ack;
      tick("table_model");
      n_checks++;
      if (irq_pulse !== tbl[i].pulse || pending !== tbl[i].pend ||
          overrun !== tbl[i].ovr || irq !== tbl[i].irq) begin
        n_err++;
        $display("FAIL vec[%0d] got pulse=%b pend=%b ovr=%b irq=%b want pulse=%b pend=%b ovr=%b irq=%b",
                 i, irq_pulse, pending, overrun, irq, tbl[i].pulse, tbl[i].pend, tbl[i].ovr, tbl[i].irq);
      end
    end
    mask_event = '0;
    ack = 4'b0010;
    tick("ack_ch1");
    ack = '0;
    mode = '0;
    repeat (2) tick("idle");

    // Pulse-mode decimation.
    clear_counts();
    edges(0, 12, "decim_n3");
    expect_int("decim_n3_count", pcnt[0], 3);
    set_n(0, 0);
    clear_counts();
    edges(0, 12, "decim_n0");
    expect_int("decim_n0_count", pcnt[0], 12);

    // Global gating holds counters at zero.
    set_n(0, 3);
    pwm_onoff = 1'b0;
    clear_counts();
    edges(0, 5, "pwm_off");
    expect_int("pwm_off_count", pcnt[0], 0);
    pwm_onoff = 1'b1;
    edges(0, 3, "pwm_on");
    expect_int("pwm_on_3edges", pcnt[0], 0);
    edges(0, 1, "pwm_on");
    expect_int("pwm_on_4th_edge", pcnt[0], 1);

    // Masked channel keeps counting.
    set_n(0, 2);
    int_onoff[0] = 1'b0;
    clear_counts();
    edges(0, 6, "int_off");
    expect_int("int_off_irq", irq_seen, 0);
    int_onoff[0] = 1'b1;
    edges(0, 2, "int_on");
    expect_int("int_on_2edges", pcnt[0], 0);
    edges(0, 1, "int_on");
    expect_int("int_on_3rd_edge", pcnt[0], 1);

    // Lowering N below the running count wraps on the next edge.
    set_n(3, 8);
    clear_counts();
    edges(3, 5, "n_change");
    set_n(3, 2);
    mask_event[3] = 1'b1;
    tick("n_change_fire");
    expect_int("n_change_fire", int'(irq_pulse[3]), 1);
    mask_event[3] = 1'b0;
    repeat (3) tick("n_change");
    edges(3, 3, "n_after");
    expect_int("n_after_count", pcnt[3], 2);

    // Async reset mid-count with a pending interrupt.
    mode = 4'b0001;
    set_n(0, 3);
    tick("sticky_setup");
    edges(0, 6, "pre_reset");
    expect_int("pre_reset_pending", int'(pending[0]), 1);
    mask_event[0] = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    mode = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_counts();
    repeat (3) tick("held_high");
    mask_event[0] = 1'b0;
    tick("held_high");
    expect_int("held_high_no_edge", pcnt[0], 0);
    edges(0, 3, "post_reset");
    expect_int("post_reset_3edges", pcnt[0], 0);
    edges(0, 1, "post_reset");
    expect_int("post_reset_4th", pcnt[0], 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0)
        for (int c = 0; c < NUM_CH; c++) set_n(c, int'($urandom_range(0, 4)));
      if (i % 50 == 0) int_onoff = NUM_CH'($urandom);
      if (i % 37 == 0) mode = NUM_CH'($urandom);
      mask_event = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) ack[c] = ($urandom_range(0, 7) == 0);
      pwm_onoff = ($urandom_range(0, 15) != 0);
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
